// File: rtl/ram_pkg.sv
// Shared definitions for the initialised byte-lane RAM: controller states and
// the supported read-latency range.
package ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ramState_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 3;

    function automatic bit latencyOk(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// One 8-bit lane of the word RAM: single port, write-first, with a LATENCY-deep
// registered read path whose stages only advance when they carry a response.
module byte_lane_ram #(
    parameter int SIZE    = 1024,
    parameter int LATENCY = 1,
    parameter int AW      = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic               i_zero,
    input  logic [AW-1:0]      i_addr,
    input  logic [7:0]         i_wdata,
    input  logic [LATENCY-1:0] i_advance,
    output logic [7:0]         o_rdata
);

    logic [7:0] r_mem   [SIZE];
    logic [7:0] r_stage [LATENCY];
    logic [7:0] w_readByte;

    assign w_readByte = i_zero ? 8'h00 : (i_we ? i_wdata : r_mem[i_addr]);

    // Storage is deliberately left out of reset; the init sweep defines it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Holding stages between loads keeps the output stable between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_stage[k] <= 8'h00;
            end
        end else begin
            if (i_advance[0]) begin
                r_stage[0] <= w_readByte;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (i_advance[k]) begin
                    r_stage[k] <= r_stage[k-1];
                end
            end
        end
    end

    assign o_rdata = r_stage[LATENCY-1];

endmodule

// File: rtl/init_byte_ram.sv
// Byte-enabled word RAM that sweeps INIT_VALUE through every word after reset
// or on request, then serves in-order reads/writes with fixed read latency.
module init_byte_ram
    import ram_pkg::*;
#(
    parameter int         BYTES_WIDTH = 4,
    parameter int         SIZE        = 1024,
    parameter int         LATENCY     = 1,
    parameter logic [7:0] INIT_VALUE  = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_req,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [BYTES_WIDTH-1:0]    req_byteenable,
    input  logic [$clog2(SIZE)-1:0]   req_addr,
    input  logic [BYTES_WIDTH*8-1:0]  req_wdata,
    output logic                      rsp_valid,
    output logic [BYTES_WIDTH*8-1:0]  rsp_rdata,
    output logic                      rsp_err,
    output logic                      init_busy
);

    localparam int            AW        = $clog2(SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);
    localparam logic [AW:0]   SIZE_W    = (AW + 1)'(SIZE);

    if (!latencyOk(LATENCY)) begin : g_badLatency
        $error("init_byte_ram: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
    end

    ramState_t          r_state;
    logic [AW-1:0]      r_sweepAddr;
    logic [LATENCY-1:0] r_valid;
    logic [LATENCY-1:0] r_err;
    logic [LATENCY-1:0] w_advance;
    logic               w_accept;
    logic               w_inRange;
    logic               w_acceptRead;
    logic               w_acceptWrite;
    logic [AW-1:0]      w_laneAddr;

    assign req_ready     = (r_state == READY) && !init_req;
    assign init_busy     = (r_state == INIT);
    assign w_accept      = req_valid && req_ready;
    assign w_inRange     = ({1'b0, req_addr} < SIZE_W);
    assign w_acceptRead  = w_accept && !req_we;
    assign w_acceptWrite = w_accept && req_we && w_inRange;
    assign w_laneAddr    = init_busy ? r_sweepAddr : req_addr;

    // Sweep lasts exactly SIZE cycles; init_req is ignored once sweeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT;
            r_sweepAddr <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_sweepAddr == LAST_ADDR) begin
                        r_state     <= READY;
                        r_sweepAddr <= '0;
                    end else begin
                        r_sweepAddr <= r_sweepAddr + 1'b1;
                    end
                end
                READY: begin
                    if (init_req) begin
                        r_state     <= INIT;
                        r_sweepAddr <= '0;
                    end
                end
                default: begin
                    r_state     <= INIT;
                    r_sweepAddr <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_advance    = '0;
        w_advance[0] = w_acceptRead;
        for (int k = 1; k < LATENCY; k++) begin
            w_advance[k] = r_valid[k-1];
        end
    end

    // Response tracking keeps running during a sweep so in-flight reads finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_err   <= '0;
        end else begin
            r_valid[0] <= w_acceptRead;
            r_err[0]   <= w_acceptRead && !w_inRange;
            for (int k = 1; k < LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_err[k]   <= r_err[k-1];
            end
        end
    end

    assign rsp_valid = r_valid[LATENCY-1];
    assign rsp_err   = r_valid[LATENCY-1] && r_err[LATENCY-1];

    for (genvar b = 0; b < BYTES_WIDTH; b++) begin : g_lane
        logic       w_laneWe;
        logic [7:0] w_laneWdata;

        assign w_laneWe    = init_busy || (w_acceptWrite && req_byteenable[b]);
        assign w_laneWdata = init_busy ? INIT_VALUE : req_wdata[8*b +: 8];

        byte_lane_ram #(
            .SIZE    (SIZE),
            .LATENCY (LATENCY),
            .AW      (AW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_we      (w_laneWe),
            .i_zero    (!w_inRange),
            .i_addr    (w_laneAddr),
            .i_wdata   (w_laneWdata),
            .i_advance (w_advance),
            .o_rdata   (rsp_rdata[8*b +: 8])
        );
    end

endmodule

// File: tb/tb_init_byte_ram.sv
// Bench for init_byte_ram: two configurations share one stimulus stream and are
// checked cycle by cycle against a word-level reference model.
module tb_init_byte_ram;

    localparam int AW = 10;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } expRsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        initReq;
    logic        reqValid;
    logic        reqWe;
    logic [3:0]  reqBe;
    logic [AW-1:0] reqAddr;
    logic [31:0] reqWdata;

    logic        readyA, rspValidA, rspErrA, busyA;
    logic [31:0] rdataA;
    logic        readyB, rspValidB, rspErrB, busyB;
    logic [31:0] rdataB;

    always #5 clk = ~clk;

    init_byte_ram #(
        .BYTES_WIDTH (4),
        .SIZE        (1024),
        .LATENCY     (1),
        .INIT_VALUE  (8'h00)
    ) dutA (
        .clk            (clk),
        .rst            (rst),
        .init_req       (initReq),
        .req_valid      (reqValid),
        .req_ready      (readyA),
        .req_we         (reqWe),
        .req_byteenable (reqBe),
        .req_addr       (reqAddr),
        .req_wdata      (reqWdata),
        .rsp_valid      (rspValidA),
        .rsp_rdata      (rdataA),
        .rsp_err        (rspErrA),
        .init_busy      (busyA)
    );

    init_byte_ram #(
        .BYTES_WIDTH (4),
        .SIZE        (1000),
        .LATENCY     (3),
        .INIT_VALUE  (8'hA5)
    ) dutB (
        .clk            (clk),
        .rst            (rst),
        .init_req       (initReq),
        .req_valid      (reqValid),
        .req_ready      (readyB),
        .req_we         (reqWe),
        .req_byteenable (reqBe),
        .req_addr       (reqAddr),
        .req_wdata      (reqWdata),
        .rsp_valid      (rspValidB),
        .rsp_rdata      (rdataB),
        .rsp_err        (rspErrB),
        .init_busy      (busyB)
    );

    int          mSize [2] = '{1024, 1000};
    int          mLat  [2] = '{1, 3};
    logic [7:0]  mInit [2] = '{8'h00, 8'hA5};
    logic [31:0] mMem  [2][1024];
    int          mBusy [2];
    logic [31:0] mLast [2];
    expRsp_t     qA[$];
    expRsp_t     qB[$];
    logic [31:0] dutLastData [2];
    logic        dutLastErr  [2];

    int cyc        = 0;
    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s cycle %0d: got %08h expected %08h", tag, cyc, actual, expected);
        end
    endtask

    task automatic startSweep(input int d);
        mBusy[d] = mSize[d];
        for (int i = 0; i < 1024; i++) begin
            mMem[d][i] = {4{mInit[d]}};
        end
    endtask

    task automatic modelReset(input int d);
        startSweep(d);
        mLast[d] = 32'h0;
        if (d == 0) qA.delete();
        else        qB.delete();
    endtask

    // One clock edge of the reference behaviour for configuration d.
    task automatic modelEdge(input int d);
        expRsp_t r;
        if (mBusy[d] > 0) begin
            mBusy[d]--;
        end else if (initReq) begin
            startSweep(d);
        end else if (reqValid) begin
            if (reqWe) begin
                if (int'(reqAddr) < mSize[d]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (reqBe[b]) mMem[d][reqAddr][8*b +: 8] = reqWdata[8*b +: 8];
                    end
                end
            end else begin
                r.due  = cyc + mLat[d];
                r.err  = (int'(reqAddr) >= mSize[d]);
                r.data = r.err ? 32'h0 : mMem[d][reqAddr];
                if (d == 0) qA.push_back(r);
                else        qB.push_back(r);
            end
        end
    endtask

    task automatic checkDut(input int d);
        string       p;
        logic        valid, err, busy, ready, haveRsp;
        logic [31:0] data;
        expRsp_t     front;
        haveRsp = 1'b0;
        if (d == 0) begin
            p = "A"; valid = rspValidA; err = rspErrA; busy = busyA; ready = readyA; data = rdataA;
            if (qA.size() > 0 && qA[0].due == cyc) begin haveRsp = 1'b1; front = qA.pop_front(); end
        end else begin
            p = "B"; valid = rspValidB; err = rspErrB; busy = busyB; ready = readyB; data = rdataB;
            if (qB.size() > 0 && qB[0].due == cyc) begin haveRsp = 1'b1; front = qB.pop_front(); end
        end
        checkOutput({p, ".init_busy"}, {31'h0, busy}, {31'h0, mBusy[d] > 0});
        checkOutput({p, ".req_ready"}, {31'h0, ready}, {31'h0, (mBusy[d] == 0) && !initReq});
        if (haveRsp) begin
            mLast[d] = front.data;
            checkOutput({p, ".rsp_valid"}, {31'h0, valid}, 32'h1);
            checkOutput({p, ".rsp_err"}, {31'h0, err}, {31'h0, front.err});
        end else begin
            checkOutput({p, ".rsp_valid"}, {31'h0, valid}, 32'h0);
            checkOutput({p, ".rsp_err"}, {31'h0, err}, 32'h0);
        end
        checkOutput({p, ".rsp_rdata"}, data, mLast[d]);
        if (valid) begin
            dutLastData[d] = data;
            dutLastErr[d]  = err;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [3:0] be,
                                 input int addr, input logic [31:0] wdata, input logic ireq);
        reqValid = v;
        reqWe    = we;
        reqBe    = be;
        reqAddr  = AW'(addr);
        reqWdata = wdata;
        initReq  = ireq;
    endtask

    task automatic randomStim(input bit allowInit);
        int addr;
        case ($urandom_range(0, 3))
            0:       addr = $urandom_range(0, 1023);
            1:       addr = $urandom_range(995, 1023);
            default: addr = $urandom_range(0, 15);
        endcase
        applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom), addr,
                      $urandom, allowInit && ($urandom_range(0, 299) == 0));
    endtask

    // Inputs are already applied just after the edge; outputs are sampled mid-cycle.
    task automatic runCycle();
        if (rst) begin
            modelReset(0);
            modelReset(1);
        end
        @(negedge clk);
        checkDut(0);
        checkDut(1);
        if (!rst) begin
            modelEdge(0);
            modelEdge(1);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b0);
            runCycle();
        end
    endtask

    task automatic waitIdle();
        while (mBusy[0] > 0 || mBusy[1] > 0 || qA.size() > 0 || qB.size() > 0) begin
            idleCycles(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b0);
        dutLastData = '{32'h0, 32'h0};
        dutLastErr  = '{1'b0, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) runCycle();
        rst = 1'b0;

        $display("[TB] initial sweep with ignored traffic");
        for (int i = 0; i < 990; i++) begin
            randomStim(1'b0);
            runCycle();
        end
        waitIdle();

        $display("[TB] read after sweep, byte-enable merge");
        applyStimulus(1'b1, 1'b0, 4'h0, 5, 32'h0, 1'b0);
        runCycle();
        idleCycles(4);
        checkOutput("A.read5", dutLastData[0], 32'h00000000);
        checkOutput("B.read5", dutLastData[1], 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b1, 4'b0101, 3, 32'hAABBCCDD, 1'b0);
        runCycle();
        applyStimulus(1'b1, 1'b0, 4'h0, 3, 32'h0, 1'b0);
        runCycle();
        idleCycles(4);
        checkOutput("A.bemerge", dutLastData[0], 32'h00BB00DD);
        checkOutput("B.bemerge", dutLastData[1], 32'hA5BBA5DD);

        $display("[TB] back-to-back reads");
        for (int a = 0; a < 3; a++) begin
            applyStimulus(1'b1, 1'b0, 4'h0, a, 32'h0, 1'b0);
            runCycle();
        end
        idleCycles(5);

        $display("[TB] out-of-range access");
        applyStimulus(1'b1, 1'b0, 4'h0, 1010, 32'h0, 1'b0);
        runCycle();
        idleCycles(4);
        checkOutput("B.oobErr", {31'h0, dutLastErr[1]}, 32'h1);
        checkOutput("B.oobData", dutLastData[1], 32'h0);
        checkOutput("A.inRangeErr", {31'h0, dutLastErr[0]}, 32'h0);
        applyStimulus(1'b1, 1'b1, 4'hF, 1010, 32'h12345678, 1'b0);
        runCycle();
        applyStimulus(1'b1, 1'b0, 4'h0, 1010, 32'h0, 1'b0);
        runCycle();
        idleCycles(4);
        checkOutput("A.write1010", dutLastData[0], 32'h12345678);

        $display("[TB] init request during traffic");
        applyStimulus(1'b1, 1'b0, 4'h0, 3, 32'h0, 1'b0);
        runCycle();
        applyStimulus(1'b1, 1'b1, 4'hF, 3, 32'hFFFFFFFF, 1'b1);
        runCycle();
        waitIdle();
        checkOutput("A.inflight", dutLastData[0], 32'h00BB00DD);
        checkOutput("B.inflight", dutLastData[1], 32'hA5BBA5DD);
        applyStimulus(1'b1, 1'b0, 4'h0, 3, 32'h0, 1'b0);
        runCycle();
        idleCycles(4);
        checkOutput("A.resweep", dutLastData[0], 32'h00000000);
        checkOutput("B.resweep", dutLastData[1], 32'hA5A5A5A5);

        $display("[TB] random traffic");
        for (int i = 0; i < 2500; i++) begin
            randomStim(1'b1);
            runCycle();
        end
        waitIdle();

        $display("[TB] reset in the middle of a sweep");
        applyStimulus(1'b0, 1'b0, 4'h0, 0, 32'h0, 1'b1);
        runCycle();
        idleCycles(500);
        rst = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        waitIdle();

        for (int i = 0; i < 500; i++) begin
            randomStim(1'b0);
            runCycle();
        end
        waitIdle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
